// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller between the L1 arrays and pipelined
// main memory. A miss stalls the pipeline, streams one block out of memory into
// the data array, writes the tag last and then releases the stall.
// Optional build macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts both the issue
// and receive sequences at the missing word and wraps within the block.
// Every output is forced to zero while rst is high.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data_in,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_address,
  output logic [15:0]       cache_data_out,
  output logic              write_tag_array
);

  localparam int OFF_W      = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W      = OFF_W + 1;
  localparam int BYTE_OFF_W = OFF_W + 1;
  localparam logic [ADDR_W-1:0] BLOCK_MASK   = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(WORDS_PER_BLOCK - 1);

  // The controller never waits on latency itself, but a zero-latency memory
  // would break the issue/receive pipelining it assumes.
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  issue_cnt, issue_cnt_next;
  logic [CNT_W-1:0]  recv_cnt, recv_cnt_next;
  logic [ADDR_W-1:0] block_base, block_base_next;
  logic [OFF_W-1:0]  issue_off, recv_off;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  start_off, start_off_next;

  // Word offset of the missing access, latched with the block base so both
  // sequences begin at the critical word.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_off <= '0;
    end else begin
      start_off <= start_off_next;
    end
  end

  // Offsets wrap inside the block because the sum is truncated to OFF_W bits.
  always_comb begin
    start_off_next = start_off;
    if (state == IDLE && miss_detected) begin
      start_off_next = miss_address[BYTE_OFF_W-1:1];
    end
    issue_off = start_off + issue_cnt[OFF_W-1:0];
    recv_off  = start_off + recv_cnt[OFF_W-1:0];
  end
`else
  // Plain fill order: both sequences start at word 0 of the block.
  always_comb begin
    issue_off = issue_cnt[OFF_W-1:0];
    recv_off  = recv_cnt[OFF_W-1:0];
  end
`endif

  // State, counters and latched block base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      block_base <= '0;
    end else begin
      state      <= state_next;
      issue_cnt  <= issue_cnt_next;
      recv_cnt   <= recv_cnt_next;
      block_base <= block_base_next;
    end
  end

  // Next-state and output decode; requests and returned data are tracked by
  // independent counters so issue and receive can overlap in one cycle.
  always_comb begin
    state_next         = state;
    issue_cnt_next     = issue_cnt;
    recv_cnt_next      = recv_cnt;
    block_base_next    = block_base;
    fsm_busy           = 1'b0;
    memory_read_en     = 1'b0;
    memory_address     = '0;
    write_data_array   = 1'b0;
    cache_word_address = '0;
    cache_data_out     = memory_data_in;
    write_tag_array    = 1'b0;

    case (state)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          block_base_next = miss_address & ~BLOCK_MASK;
          issue_cnt_next  = '0;
          recv_cnt_next   = '0;
          state_next      = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < CNT_FULL) begin
          memory_read_en = 1'b1;
          memory_address = block_base + {{(ADDR_W-BYTE_OFF_W){1'b0}}, issue_off, 1'b0};
          issue_cnt_next = issue_cnt + 1'b1;
        end
        if (memory_data_valid && recv_cnt < CNT_FULL) begin
          write_data_array   = 1'b1;
          cache_word_address = block_base + {{(ADDR_W-BYTE_OFF_W){1'b0}}, recv_off, 1'b0};
          recv_cnt_next      = recv_cnt + 1'b1;
          if (recv_cnt == CNT_LAST) begin
            state_next = TAG;
          end
        end
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rst) begin
      fsm_busy           = 1'b0;
      memory_read_en     = 1'b0;
      memory_address     = '0;
      write_data_array   = 1'b0;
      cache_word_address = '0;
      cache_data_out     = '0;
      write_tag_array    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for cache_fill_fsm. Expected read and
// write addresses come from hand-written order tables; a pipelined memory
// model returns data MEM_LATENCY cycles after each request (request cycle
// counted as the first). Honours CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int WORDS  = 8;
  localparam int LAT    = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  addr_t       miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        fsm_busy;
  logic        memory_read_en;
  addr_t       memory_address;
  logic        write_data_array;
  addr_t       cache_word_address;
  logic [15:0] cache_data_out;
  logic        write_tag_array;

  logic        model_valid = 1'b0;
  logic [15:0] model_data  = '0;
  logic        force_valid = 1'b0;
  logic [15:0] force_data  = '0;

  int    vectors      = 0;
  int    miscompares  = 0;
  int    cyc          = 0;
  int    tags_pending = 0;
  addr_t exp_rd[$];
  addr_t exp_wr[$];
  int    mem_due[$];
  addr_t mem_addr[$];

  addr_t ord_1236 [WORDS];
  addr_t ord_5674 [WORDS];
  addr_t ord_4000 [WORDS];
  addr_t ord_0a40 [WORDS];
  addr_t ord_0b50 [WORDS];
  addr_t ord_fff8 [WORDS];
  addr_t ord_123a [WORDS];

  assign memory_data_valid = model_valid | force_valid;
  assign memory_data_in    = model_valid ? model_data : force_data;

  cache_fill_fsm #(
    .ADDR_W(ADDR_W),
    .WORDS_PER_BLOCK(WORDS),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data_in(memory_data_in),
    .fsm_busy(fsm_busy),
    .memory_read_en(memory_read_en),
    .memory_address(memory_address),
    .write_data_array(write_data_array),
    .cache_word_address(cache_word_address),
    .cache_data_out(cache_data_out),
    .write_tag_array(write_tag_array)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input addr_t a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Memory model, request side: remember each read and when its data is due.
  always @(negedge clk) begin
    if (memory_read_en) begin
      mem_due.push_back(cyc + LAT - 1);
      mem_addr.push_back(memory_address);
    end
  end

  // Memory model, return side: present due data shortly after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mem_due.size() != 0 && mem_due[0] == cyc) begin
      void'(mem_due.pop_front());
      model_data  = mem_word(mem_addr.pop_front());
      model_valid = 1'b1;
    end else begin
      model_valid = 1'b0;
      model_data  = '0;
    end
  end

  // Monitor: every DUT read, data write and tag pulse consumes a scoreboard entry.
  always @(negedge clk) begin : monitor
    addr_t e;
    if (memory_read_en) begin
      if (exp_rd.size() == 0) begin
        check_output("read_unexpected", 32'(memory_read_en), 32'd0);
      end else begin
        e = exp_rd.pop_front();
        check_output("read_addr", 32'(memory_address), 32'(e));
      end
    end
    if (write_data_array) begin
      if (exp_wr.size() == 0) begin
        check_output("write_unexpected", 32'(write_data_array), 32'd0);
      end else begin
        e = exp_wr.pop_front();
        check_output("write_addr", 32'(cache_word_address), 32'(e));
        check_output("write_data", 32'(cache_data_out), 32'(mem_word(e)));
      end
    end
    if (write_tag_array) begin
      if (tags_pending == 0) begin
        check_output("tag_unexpected", 32'(write_tag_array), 32'd0);
      end else begin
        tags_pending--;
      end
    end
  end

  // One complete fill starting in the current cycle; optionally keeps
  // miss_detected high with another address so the next miss chains on.
  task automatic apply_stimulus(input addr_t addr, input addr_t order [WORDS],
                                input bit hold, input addr_t hold_addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int i = 0; i < WORDS; i++) begin
      exp_rd.push_back(order[i]);
      exp_wr.push_back(order[i]);
    end
    tags_pending++;
    @(negedge clk);
    check_output("busy_on_miss", 32'(fsm_busy), 32'd1);
    @(posedge clk); #1;
    if (hold) miss_address = hold_addr;
    else miss_detected = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_output("busy_during_fill", 32'(fsm_busy), 32'd1);
      if (k == 3 || k == 4) check_output("first_data_timing", 32'(write_data_array), 32'(k == 4));
      if (k >= 11) check_output("tag_timing", 32'(write_tag_array), 32'(k == 12));
      @(posedge clk); #1;
    end
    if (!hold) begin
      @(negedge clk);
      check_output("busy_release", 32'(fsm_busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    ord_1236 = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
    ord_5674 = '{16'h5674, 16'h5676, 16'h5678, 16'h567A, 16'h567C, 16'h567E, 16'h5670, 16'h5672};
    ord_fff8 = '{16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE, 16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6};
    ord_123a = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
`else
    ord_1236 = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    ord_5674 = '{16'h5670, 16'h5672, 16'h5674, 16'h5676, 16'h5678, 16'h567A, 16'h567C, 16'h567E};
    ord_fff8 = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE};
    ord_123a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif
    ord_4000 = '{16'h4000, 16'h4002, 16'h4004, 16'h4006, 16'h4008, 16'h400A, 16'h400C, 16'h400E};
    ord_0a40 = '{16'h0A40, 16'h0A42, 16'h0A44, 16'h0A46, 16'h0A48, 16'h0A4A, 16'h0A4C, 16'h0A4E};
    ord_0b50 = '{16'h0B50, 16'h0B52, 16'h0B54, 16'h0B56, 16'h0B58, 16'h0B5A, 16'h0B5C, 16'h0B5E};

    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;

    // Reset with active inputs: everything stays quiet.
    for (int i = 0; i < 2; i++) begin
      miss_detected = 1'b1;
      miss_address  = 16'($urandom);
      force_valid   = 1'b1;
      force_data    = 16'($urandom) | 16'h0001;
      @(negedge clk);
      check_output("rst_busy", 32'(fsm_busy), 32'd0);
      check_output("rst_read_en", 32'(memory_read_en), 32'd0);
      check_output("rst_write_data", 32'(write_data_array), 32'd0);
      check_output("rst_write_tag", 32'(write_tag_array), 32'd0);
      check_output("rst_data_out", 32'(cache_data_out), 32'd0);
      @(posedge clk); #1;
    end
    rst           = 1'b0;
    miss_detected = 1'b0;
    force_valid   = 1'b0;
    force_data    = '0;
    @(negedge clk);
    check_output("idle_busy", 32'(fsm_busy), 32'd0);
    check_output("idle_read_en", 32'(memory_read_en), 32'd0);
    @(posedge clk); #1;

    $display("[TB] basic fill at 0x1236");
    apply_stimulus(16'h1236, ord_1236, 1'b0, '0);

    $display("[TB] miss held during fill, chained fill at 0x4000");
    apply_stimulus(16'h5674, ord_5674, 1'b1, 16'h4000);
    apply_stimulus(16'h4000, ord_4000, 1'b0, '0);

    $display("[TB] reset after three data writes");
    miss_detected = 1'b1;
    miss_address  = 16'h0A40;
    for (int i = 0; i < WORDS; i++) begin
      exp_rd.push_back(ord_0a40[i]);
      exp_wr.push_back(ord_0a40[i]);
    end
    tags_pending++;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_output("reads_before_abort", 32'(exp_rd.size()), 32'd2);
    check_output("writes_before_abort", 32'(exp_wr.size()), 32'd5);
    rst = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    tags_pending = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_busy", 32'(fsm_busy), 32'd0);
    check_output("abort_read_en", 32'(memory_read_en), 32'd0);
    check_output("abort_write_data", 32'(write_data_array), 32'd0);
    check_output("abort_write_tag", 32'(write_tag_array), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_output("stale_valid_ignored", 32'(write_data_array), 32'd0);
    end
    @(posedge clk); #1;
    apply_stimulus(16'h0B50, ord_0b50, 1'b0, '0);

    $display("[TB] fill at top of memory 0xFFF8");
    apply_stimulus(16'hFFF8, ord_fff8, 1'b0, '0);

    $display("[TB] fill at 0x123A");
    apply_stimulus(16'h123A, ord_123a, 1'b0, '0);

    repeat (4) begin
      @(posedge clk); #1;
    end
    check_output("reads_outstanding", 32'(exp_rd.size()), 32'd0);
    check_output("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check_output("tags_outstanding", 32'(tags_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
